// File: rtl/cblock_cfgchain_if.sv
// rtl/cblock_cfgchain_if.sv - configuration chain and routing track bundle for cblock_cfgchain
interface cblock_cfgchain_if #(
   parameter int W = 3
);
   logic         cfg_shift_en;
   logic         cfg_din;
   logic         cfg_dout;
   logic         cfg_commit;
   logic         cfg_done;
   logic         cfg_err;
   logic [W-1:0] left_i;
   logic [W-1:0] right_o;
   logic         up_i;
   logic         up_o;
   logic         down_i;
   logic         down_o;

   modport slave (
      input  cfg_shift_en, cfg_din, cfg_commit, left_i, up_i, down_i,
      output cfg_dout, cfg_done, cfg_err, right_o, up_o, down_o
   );

   modport master (
      output cfg_shift_en, cfg_din, cfg_commit, left_i, up_i, down_i,
      input  cfg_dout, cfg_done, cfg_err, right_o, up_o, down_o
   );
endinterface

// File: rtl/cblock_cfgchain.sv
// rtl/cblock_cfgchain.sv - connection block with serial shadow/active config chain (optional CBLOCK_CFG_PARITY_EN)
module cblock_cfgchain #(
   parameter int W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   cblock_cfgchain_if.slave  bus
);
   localparam int CFG_BITS = 6 * W;
`ifdef CBLOCK_CFG_PARITY_EN
   localparam int SH_BITS  = CFG_BITS + 1;
`else
   localparam int SH_BITS  = CFG_BITS;
`endif
   localparam int EXPECTED = SH_BITS;
   localparam int CNT_W    = $clog2(EXPECTED + 2);
   localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(EXPECTED);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(EXPECTED + 1);

   logic [SH_BITS-1:0]  r_shadow;
   logic [CFG_BITS-1:0] r_active;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done;
   logic                r_err;

   logic                w_check_ok;
   logic                w_commit_ok;
   logic                w_shift;
   logic [CFG_BITS-1:0] w_cfg_data;

   // Data bits sit at the top of the shadow; a parity bit, when present, is the LSB
   assign w_cfg_data = r_shadow[SH_BITS-1 -: CFG_BITS];
`ifdef CBLOCK_CFG_PARITY_EN
   assign w_check_ok = ~(^r_shadow);
`else
   assign w_check_ok = 1'b1;
`endif
   assign w_commit_ok = bus.cfg_commit && (r_cnt == CNT_EXP) && w_check_ok;
   // A commit in the same cycle swallows any shift request
   assign w_shift     = bus.cfg_shift_en && !bus.cfg_commit;

   // Serial shadow load, first bit in ends up at the MSB after a full load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else if (w_shift) begin
         r_shadow <= {r_shadow[SH_BITS-2:0], bus.cfg_din};
      end
   end

   // Saturating count of accepted shifts since the last commit attempt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (bus.cfg_commit) begin
         r_cnt <= '0;
      end else if (w_shift && (r_cnt != CNT_SAT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Atomic copy of a validated shadow into the active configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= '0;
      end else if (w_commit_ok) begin
         r_active <= w_cfg_data;
      end
   end

   // Commit status: one-cycle done pulse, sticky error until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_commit_ok;
         if (bus.cfg_commit && !w_commit_ok) begin
            r_err <= 1'b1;
         end
      end
   end

   logic [W-1:0] w_vl, w_vr, w_lu, w_dr, w_ur, w_ld;
   assign w_vl = r_active[6*W-1 -: W];
   assign w_vr = r_active[5*W-1 -: W];
   assign w_lu = r_active[4*W-1 -: W];
   assign w_dr = r_active[3*W-1 -: W];
   assign w_ur = r_active[2*W-1 -: W];
   assign w_ld = r_active[W-1  -: W];

   logic [W:0]   w_l;
   logic [W:0]   w_r;
   logic [W-1:0] w_h;
   logic [W-1:0] w_right;

   // Priority-mux routing: left column climbs, horizontals tap it, right column descends
   always_comb begin
      w_l     = '0;
      w_r     = '0;
      w_h     = '0;
      w_right = '0;
      w_l[0]  = bus.down_i;
      for (int i = 0; i < W; i++) begin
         w_l[i+1] = w_vl[i] ? w_l[i] : (w_lu[i] ? bus.left_i[i] : 1'b0);
      end
      for (int i = 0; i < W; i++) begin
         w_h[i] = w_dr[i] ? w_l[i] : bus.left_i[i];
      end
      w_r[W] = bus.up_i;
      for (int i = W - 1; i >= 0; i--) begin
         w_r[i] = w_vr[i] ? w_r[i+1] : (w_ld[i] ? w_h[i] : 1'b0);
      end
      for (int i = 0; i < W; i++) begin
         w_right[i] = w_ur[i] ? w_r[i+1] : w_h[i];
      end
   end

   assign bus.right_o  = w_right;
   assign bus.up_o     = w_l[W];
   assign bus.down_o   = w_r[0];
   assign bus.cfg_dout = r_shadow[SH_BITS-1];
   assign bus.cfg_done = r_done;
   assign bus.cfg_err  = r_err;
endmodule
